// File: rtl/uart_tx_fifo.sv
// +--------------------------------------------------------------------------+
// | uart_tx_fifo : UART transmitter with transmit FIFO, baud divider, parity |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int CLK_DIV    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_doneH,
  output logic [CNT_W-1:0]     fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BCNT_W = $clog2(CLK_DIV);
  localparam int BIDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0]  c_FULL      = CNT_W'(FIFO_DEPTH);
  localparam logic [BCNT_W-1:0] c_BIT_LAST  = BCNT_W'(CLK_DIV - 1);
  localparam logic [BIDX_W-1:0] c_DATA_LAST = BIDX_W'(DATA_BITS - 1);
  localparam logic              c_STOP_LAST = (STOP_BITS == 2);
  localparam logic              c_PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]     r_count;

  state_t               r_state;
  logic [BCNT_W-1:0]    r_bcnt;
  logic [BIDX_W-1:0]    r_bidx;
  logic                 r_sidx;
  logic [DATA_BITS-1:0] r_tsr;
  logic                 r_par;
  logic                 r_txd;
  logic                 r_busy;
  logic                 r_done;

  state_t               w_state_nxt;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_shift;
  logic                 w_bit_end;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_txd_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic [BIDX_W-1:0]    w_bidx_nxt;
  logic                 w_sidx_nxt;

  assign tx_ready   = (r_count != c_FULL);
  assign w_push     = tx_valid & tx_ready;
  assign w_head     = r_mem[r_rptr];
  assign w_bit_end  = (r_bcnt == c_BIT_LAST);
  assign txd        = r_txd;
  assign tx_busy    = r_busy;
  assign tx_doneH   = r_done;
  assign fifo_count = r_count;

  // Storage carries no reset: contents are meaningless while the count is zero.
  always_ff @(posedge sysclk) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_bidx  <= '0;
      r_sidx  <= 1'b0;
      r_tsr   <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bidx  <= w_bidx_nxt;
      r_sidx  <= w_sidx_nxt;
      r_txd   <= w_txd_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      if (r_state == S_IDLE || w_bit_end) r_bcnt <= '0;
      else                                r_bcnt <= r_bcnt + 1'b1;
      // Parity is fixed at load time so the shifter can consume the word freely.
      if (w_pop) begin
        r_tsr <= w_head;
        r_par <= (^w_head) ^ c_PAR_ODD;
      end else if (w_shift) begin
        r_tsr <= r_tsr >> 1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    w_txd_nxt   = r_txd;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_bidx_nxt  = r_bidx;
    w_sidx_nxt  = r_sidx;
    case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bidx_nxt  = '0;
          w_txd_nxt   = r_tsr[0];
          w_shift     = 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bidx == c_DATA_LAST) begin
            if (PARITY_EN != 0) begin
              w_state_nxt = S_PARITY;
              w_txd_nxt   = r_par;
            end else begin
              w_state_nxt = S_STOP;
              w_txd_nxt   = 1'b1;
              w_sidx_nxt  = 1'b0;
            end
          end else begin
            w_bidx_nxt = r_bidx + 1'b1;
            w_txd_nxt  = r_tsr[0];
            w_shift    = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_txd_nxt   = 1'b1;
          w_sidx_nxt  = 1'b0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_sidx == c_STOP_LAST) begin
            w_done_nxt = 1'b1;
            if (r_count != '0) begin
              w_pop       = 1'b1;
              w_state_nxt = S_START;
              w_txd_nxt   = 1'b0;
            end else begin
              w_state_nxt = S_IDLE;
              w_busy_nxt  = 1'b0;
            end
          end else begin
            w_sidx_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire
